// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
package imem_pkg;

   localparam logic [31:0] NOP_INST = 32'h00000000;

   typedef enum logic {FETCH = 1'b0, LOADER = 1'b1} owner_t;

   typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

   // A byte address is unusable when it is not word aligned or its word
   // index lies past the last implemented instruction word.
   function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/imem_rr_grant.sv
// Two-requester round-robin grant (fetch vs loader) with a last-grant register.
// On a conflict the requester that did not win last time is granted.
module imem_rr_grant
   import imem_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_fetch,
   input  logic req_loader,
   input  logic update,
   input  logic force_loader,
   output logic gnt_fetch,
   output logic gnt_loader
);

   owner_t last_grant;

   // Grant the lone requester, or the one not granted last on a conflict
   always_comb begin
      gnt_fetch  = 1'b0;
      gnt_loader = 1'b0;
      if (req_fetch && req_loader) begin
         if (last_grant == LOADER) gnt_fetch  = 1'b1;
         else                      gnt_loader = 1'b1;
      end else begin
         gnt_fetch  = req_fetch;
         gnt_loader = req_loader;
      end
   end

   // Remember the conflict winner; a finished loader lock counts as a loader win
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= LOADER;
      end else if (force_loader) begin
         last_grant <= LOADER;
      end else if (update && req_fetch && req_loader) begin
         last_grant <= gnt_loader ? LOADER : FETCH;
      end
   end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one single-port synchronous-read instruction RAM between the fetch
// stage and the program loader. Round-robin arbitration, loader lock for
// download bursts, and range checking that turns bad addresses into faults.
// Handshake: a request transfers on a rising edge where req && ready; ready is
// combinational from req and state; requesters hold address/data until accepted.
// Optional build macro: IMEM_PERF_CNT_EN adds f_stall_cnt and conflict_cnt.
module imem_port_arbiter
   import imem_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [31:0]       f_pc,
   output logic              f_ready,
   output logic              f_rvalid,
   output logic [31:0]       f_rdata,
   output logic              f_fault,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic              ld_lock,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_wdata,
   output logic              ld_ready,
   output logic              ld_rvalid,
   output logic [31:0]       ld_rdata,
   output logic              ld_fault,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
`ifdef IMEM_PERF_CNT_EN
   ,
   output logic [31:0]       f_stall_cnt,
   output logic [31:0]       conflict_cnt
`endif
);

   state_t state, state_nxt;
   logic   gnt_f, gnt_l;
   logic   rr_update, rr_force_ld;
   logic   acc_f, acc_l;
   logic   f_bad, l_bad;
   logic   f_pend, f_pend_bad;
   logic   l_pend, l_pend_bad;
   logic   l_flt_q;

   imem_rr_grant u_rr (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_fetch    (f_req),
      .req_loader   (ld_req),
      .update       (rr_update),
      .force_loader (rr_force_ld),
      .gnt_fetch    (gnt_f),
      .gnt_loader   (gnt_l)
   );

   assign f_bad = addr_fault(f_pc, DEPTH);
   assign l_bad = addr_fault(ld_addr, DEPTH);
   assign acc_f = f_req && f_ready;
   assign acc_l = ld_req && ld_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ARB;
      else        state <= state_nxt;
   end

   // Ready generation and next state; nothing is granted while in reset
   always_comb begin
      state_nxt   = state;
      f_ready     = 1'b0;
      ld_ready    = 1'b0;
      rr_update   = 1'b0;
      rr_force_ld = 1'b0;
      if (rst_n) begin
         case (state)
            ARB: begin
               f_ready   = gnt_f;
               ld_ready  = gnt_l;
               rr_update = 1'b1;
               if (gnt_l && ld_lock) state_nxt = LOCK;
            end
            LOCK: begin
               ld_ready = ld_req;
               if (!ld_lock) begin
                  state_nxt   = ARB;
                  rr_force_ld = 1'b1;
               end
            end
            default: state_nxt = ARB;
         endcase
      end
   end

   // Memory command from the accepted request; faulted accesses never reach the RAM
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (acc_f && !f_bad) begin
         mem_en   = 1'b1;
         mem_addr = f_pc[ADDR_W+1:2];
      end else if (acc_l && !l_bad) begin
         mem_en   = 1'b1;
         mem_we   = ld_we;
         mem_addr = ld_addr[ADDR_W+1:2];
         if (ld_we) mem_wdata = ld_wdata;
      end
   end

   // Track which port owns next cycle's response and whether it faulted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_pend     <= 1'b0;
         f_pend_bad <= 1'b0;
         l_pend     <= 1'b0;
         l_pend_bad <= 1'b0;
         l_flt_q    <= 1'b0;
      end else begin
         f_pend     <= acc_f;
         f_pend_bad <= acc_f && f_bad;
         l_pend     <= acc_l && !ld_we;
         l_pend_bad <= acc_l && !ld_we && l_bad;
         l_flt_q    <= acc_l && l_bad;
      end
   end

   assign f_rvalid  = f_pend;
   assign f_fault   = f_pend_bad;
   assign f_rdata   = (f_pend && !f_pend_bad) ? mem_rdata : NOP_INST;
   assign ld_rvalid = l_pend;
   assign ld_fault  = l_flt_q;
   assign ld_rdata  = (l_pend && !l_pend_bad) ? mem_rdata : NOP_INST;

`ifdef IMEM_PERF_CNT_EN
   // Saturating counters of refused fetch cycles and arbitration conflicts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_stall_cnt  <= '0;
         conflict_cnt <= '0;
      end else begin
         if (f_req && !f_ready && (f_stall_cnt != '1))
            f_stall_cnt <= f_stall_cnt + 32'd1;
         if ((state == ARB) && f_req && ld_req && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter with a behavioural RAM, a
// reference arbitration model and response queues.
module tb_imem_port_arbiter;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              f_req = 1'b0;
   logic [31:0]       f_pc = '0;
   logic              f_ready, f_rvalid, f_fault;
   logic [31:0]       f_rdata;
   logic              ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
   logic [31:0]       ld_addr = '0, ld_wdata = '0;
   logic              ld_ready, ld_rvalid, ld_fault;
   logic [31:0]       ld_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = '0;
`ifdef IMEM_PERF_CNT_EN
   logic [31:0]       f_stall_cnt, conflict_cnt;
`endif

   imem_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_pc(f_pc), .f_ready(f_ready), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_fault(f_fault),
      .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
      .ld_wdata(ld_wdata), .ld_ready(ld_ready), .ld_rvalid(ld_rvalid),
      .ld_rdata(ld_rdata), .ld_fault(ld_fault),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_PERF_CNT_EN
      , .f_stall_cnt(f_stall_cnt), .conflict_cnt(conflict_cnt)
`endif
   );

   // Clock
   always #5 clk = ~clk;

   // Behavioural single-port synchronous-read RAM, seeded once during reset
   logic [31:0] seed [DEPTH];
   logic [31:0] ram  [DEPTH];
   logic        ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= seed[i];
         ram_loaded <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata    <= ram[mem_addr];
      end
   end

   // Scoreboard state
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [32:0] f_q[$];        // {fault, data}
   logic [33:0] l_q[$];        // {is_read, fault, data}
   logic [31:0] ref_mem [DEPTH];
   logic        m_lock;
   logic        m_last_ld;
   int          m_stall;
   int          m_conf;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
   endfunction

   function automatic logic [31:0] rand_addr();
      int unsigned k = $urandom_range(0, 9);
      logic [31:0] a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (k == 0) a = a + 32'h100;
      if (k == 1) a = a | 32'($urandom_range(1, 3));
      return a;
   endfunction

   task automatic model_clear();
      f_q.delete();
      l_q.delete();
      m_lock    = 1'b0;
      m_last_ld = 1'b1;
      m_stall   = 0;
      m_conf    = 0;
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_f_ready"},   f_ready,   0);
      check({pfx, "_f_rvalid"},  f_rvalid,  0);
      check({pfx, "_f_rdata"},   f_rdata,   0);
      check({pfx, "_f_fault"},   f_fault,   0);
      check({pfx, "_ld_ready"},  ld_ready,  0);
      check({pfx, "_ld_rvalid"}, ld_rvalid, 0);
      check({pfx, "_ld_rdata"},  ld_rdata,  0);
      check({pfx, "_ld_fault"},  ld_fault,  0);
      check({pfx, "_mem_en"},    mem_en,    0);
      check({pfx, "_mem_we"},    mem_we,    0);
      check({pfx, "_mem_addr"},  mem_addr,  0);
      check({pfx, "_mem_wdata"}, mem_wdata, 0);
`ifdef IMEM_PERF_CNT_EN
      check({pfx, "_stall_cnt"}, f_stall_cnt,  0);
      check({pfx, "_conf_cnt"},  conflict_cnt, 0);
`endif
   endtask

   task automatic set_idle();
      f_req = 1'b0; f_pc = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0; ld_addr = '0; ld_wdata = '0;
   endtask

   task automatic do_reset();
      set_idle();
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_zero("rst");
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Drive one cycle, check handshake/memory/responses, advance the model
   task automatic step(input logic fr, input logic [31:0] fpc,
                       input logic lr, input logic lwe, input logic llock,
                       input logic [31:0] laddr, input logic [31:0] lwd,
                       output logic acc_f, output logic acc_l);
      logic        ef, el, e_en, fb, lb;
      logic [32:0] fe;
      logic [33:0] le;
      f_req = fr; f_pc = fpc;
      ld_req = lr; ld_we = lwe; ld_lock = llock; ld_addr = laddr; ld_wdata = lwd;
      @(negedge clk);
      if (m_lock) begin
         ef = 1'b0; el = lr;
      end else if (fr && lr) begin
         ef = m_last_ld; el = !m_last_ld;
      end else begin
         ef = fr; el = lr;
      end
      check("f_ready", f_ready, ef);
      check("ld_ready", ld_ready, el);
      acc_f = fr && ef;
      acc_l = lr && el;
      fb = bad(fpc);
      lb = bad(laddr);
      // Responses for last cycle's accepts
      check("f_rvalid", f_rvalid, f_q.size() != 0);
      if (f_q.size() != 0) begin
         fe = f_q.pop_front();
         check("f_rdata", f_rdata, fe[31:0]);
         check("f_fault", f_fault, fe[32]);
      end
      if (l_q.size() != 0) begin
         le = l_q.pop_front();
         check("ld_rvalid", ld_rvalid, le[33]);
         check("ld_fault", ld_fault, le[32]);
         if (le[33]) check("ld_rdata", ld_rdata, le[31:0]);
      end else begin
         check("ld_rvalid", ld_rvalid, 0);
         check("ld_fault", ld_fault, 0);
      end
      // Memory command
      e_en = (acc_f && !fb) || (acc_l && !lb);
      check("mem_en", mem_en, e_en);
      if (e_en) begin
         check("mem_addr", mem_addr, acc_f ? fpc[7:2] : laddr[7:2]);
         check("mem_we", mem_we, acc_l && lwe);
         if (acc_l && lwe) check("mem_wdata", mem_wdata, lwd);
      end
      // Expected responses
      if (acc_f) f_q.push_back({fb, fb ? 32'h0 : ref_mem[fpc[7:2]]});
      if (acc_l) begin
         if (!lwe)    l_q.push_back({1'b1, lb, lb ? 32'h0 : ref_mem[laddr[7:2]]});
         else if (lb) l_q.push_back({1'b0, 1'b1, 32'h0});
         else         ref_mem[laddr[7:2]] = lwd;
      end
      if (fr && !ef) m_stall++;
      if (!m_lock && fr && lr) m_conf++;
      @(posedge clk);
      if (m_lock) begin
         if (!llock) begin m_lock = 1'b0; m_last_ld = 1'b1; end
      end else begin
         if (fr && lr) m_last_ld = el;
         if (el && llock) m_lock = 1'b1;
      end
      #1;
   endtask

   task automatic idle_step();
      logic a, b;
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, a, b);
   endtask

   initial begin
      logic        af, al;
      logic        fr, lr, lwe, llock, fh, lh;
      logic [31:0] fpc, laddr, lwd, w3;
      int          fi, li;

      for (int i = 0; i < DEPTH; i++) begin
         seed[i]    = $urandom;
         ref_mem[i] = seed[i];
      end
      model_clear();
      do_reset();

      // Reset in the middle of a read: the response must never appear
      step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, af, al);
      set_idle();
      rst_n = 1'b0;
      #1;
      check("midrst_f_rvalid", f_rvalid, 0);
      check_zero("midrst");
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_step();
      idle_step();

      // Back-to-back fetches of words 0, 1, 2
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, af, al);
      idle_step();

      // Conflict right after reset: fetch wins first, then alternation
      do_reset();
      fi = 0; li = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'h10 + 32'(fi * 4), 1'b1, 1'b0, 1'b0, 32'h40 + 32'(li * 4), 32'h0, af, al);
         if (af) fi++;
         if (al) li++;
      end
      idle_step();
      check("conflict_f_grants", 32'(fi), 3);
      check("conflict_l_grants", 32'(li), 2);
`ifdef IMEM_PERF_CNT_EN
      check("conflict_cnt_5", conflict_cnt, 5);
      check("stall_cnt_conflict", f_stall_cnt, 32'(m_stall));
`endif

      // Locked loader burst writing words 0..7 while fetch waits for word 3
      do_reset();
      w3 = '0;
      for (int k = 0; k < 8; k++) begin
         lwd = $urandom;
         if (k == 3) w3 = lwd;
         step(k > 0, 32'h0C, 1'b1, 1'b1, k < 7, 32'(k * 4), lwd, af, al);
         if (k > 0) check("lock_f_refused", af, 0);
      end
      step(1'b1, 32'h0C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, af, al);
      check("lock_fetch_after", af, 1);
      check("lock_word3_model", ref_mem[3], w3);
      idle_step();

      // Read-after-write through the RAM
      lwd = $urandom;
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h14, lwd, af, al);
      step(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, af, al);
      idle_step();

      // Range boundaries and faults
      step(1'b1, 32'hFC,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0, af, al);
      step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, af, al);
      step(1'b1, 32'h02,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0, af, al);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF, af, al);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h101, 32'h0, af, al);
      step(1'b1, 32'h04,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0, af, al);
      idle_step();
      check("fault_word1_intact", ram[1], ref_mem[1]);

      // Random traffic; requesters hold their request until accepted
      fh = 1'b0; lh = 1'b0;
      fr = 1'b0; lr = 1'b0; lwe = 1'b0; llock = 1'b0;
      fpc = '0; laddr = '0; lwd = '0;
      for (int c = 0; c < 400; c++) begin
         if (!fh) begin
            fr  = ($urandom_range(0, 3) != 0);
            fpc = rand_addr();
         end
         if (!lh) begin
            lr    = ($urandom_range(0, 2) != 0);
            lwe   = $urandom_range(0, 1) == 1;
            llock = ($urandom_range(0, 7) == 0);
            laddr = rand_addr();
            lwd   = $urandom;
         end
         step(fr, fpc, lr, lwe, llock, laddr, lwd, af, al);
         fh = fr && !af;
         lh = lr && !al;
      end
      for (int c = 0; c < 3; c++) idle_step();
      check("f_q_drained", 32'(f_q.size()), 0);
      check("l_q_drained", 32'(l_q.size()), 0);
`ifdef IMEM_PERF_CNT_EN
      check("stall_cnt_final", f_stall_cnt, 32'(m_stall));
      check("conflict_cnt_final", conflict_cnt, 32'(m_conf));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
